// File: rtl/rpn_ctrl_pkg.sv
// Shared types and constants for the RPN stack controller.
// Holds FSM state, undo-history kind, ALU opcode values and flag bit positions.
package rpn_ctrl_pkg;

  typedef enum logic {
    StIdle,
    StExec
  } state_e;

  typedef enum logic [1:0] {
    HistNone,
    HistPush,
    HistOp
  } hist_e;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpAnd = 2'b10;
  localparam logic [1:0] OpOr  = 2'b11;

  localparam int unsigned FlagN = 4;
  localparam int unsigned FlagZ = 3;
  localparam int unsigned FlagC = 2;
  localparam int unsigned FlagV = 1;
  localparam int unsigned FlagP = 0;

  localparam int unsigned NumFlags = 5;

endpackage

// File: rtl/operand_stack_regfile.sv
// Operand stack storage: DEPTH x WIDTH registers, two write ports, and
// combinational reads of the top two live entries selected by the current depth.
module operand_stack_regfile #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [$clog2(Depth+1)-1:0]   depth_i,
  input  logic                         wa_en_i,
  input  logic [$clog2(Depth)-1:0]     wa_addr_i,
  input  logic [Width-1:0]             wa_data_i,
  input  logic                         wb_en_i,
  input  logic [$clog2(Depth)-1:0]     wb_addr_i,
  input  logic [Width-1:0]             wb_data_i,
  output logic [Width-1:0]             top_o,
  output logic [Width-1:0]             next_o
);

  localparam int unsigned DW = $clog2(Depth + 1);
  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    next_idx;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wa_en_i) mem_q[wa_addr_i] <= wa_data_i;
      if (wb_en_i) mem_q[wb_addr_i] <= wb_data_i;
    end
  end

  always_comb begin
    top_idx  = AW'(depth_i - DW'(1));
    next_idx = AW'(depth_i - DW'(2));
    top_o    = (depth_i == '0)     ? '0 : mem_q[top_idx];
    next_o   = (depth_i < DW'(2))  ? '0 : mem_q[next_idx];
  end

endmodule

// File: rtl/rpn_stack_controller.sv
// Stack-machine sequencer around a combinational ALU: push on enter, pop two and
// write back on op (two-cycle IDLE/EXEC), and a single-level undo of the last push or op.
module rpn_stack_controller
  import rpn_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enter_pulse,
  input  logic                         op_pulse,
  input  logic                         undo_pulse,
  input  logic [WIDTH-1:0]             data_in,
  input  logic [1:0]                   opcode_in,
  input  logic [WIDTH-1:0]             alu_result,
  input  logic [4:0]                   alu_flags,
  output logic [WIDTH-1:0]             alu_a,
  output logic [WIDTH-1:0]             alu_b,
  output logic [1:0]                   alu_opcode,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic [4:0]                   flags,
  output logic                         busy,
  output logic                         error,
  output logic [2:0]                   status
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [DW-1:0] DepthMax = DW'(DEPTH);

  state_e           state_q, state_d;
  hist_e            hist_q, hist_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [WIDTH-1:0] saved_a_q, saved_a_d;
  logic [WIDTH-1:0] saved_b_q, saved_b_d;
  logic [4:0]       saved_flags_q, saved_flags_d;
  logic [4:0]       flags_q, flags_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_opc_q, alu_opc_d;
  logic             error_q, error_d;

  logic             wa_en, wb_en;
  logic [AW-1:0]    wa_addr, wb_addr;
  logic [WIDTH-1:0] wa_data, wb_data;
  logic [WIDTH-1:0] rd_top, rd_next;

  operand_stack_regfile #(
    .Width (WIDTH),
    .Depth (DEPTH)
  ) u_stack (
    .clk_i     (clk),
    .reset_i   (reset),
    .depth_i   (depth_q),
    .wa_en_i   (wa_en),
    .wa_addr_i (wa_addr),
    .wa_data_i (wa_data),
    .wb_en_i   (wb_en),
    .wb_addr_i (wb_addr),
    .wb_data_i (wb_data),
    .top_o     (rd_top),
    .next_o    (rd_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      hist_q        <= HistNone;
      depth_q       <= '0;
      saved_a_q     <= '0;
      saved_b_q     <= '0;
      saved_flags_q <= '0;
      flags_q       <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_opc_q     <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      hist_q        <= hist_d;
      depth_q       <= depth_d;
      saved_a_q     <= saved_a_d;
      saved_b_q     <= saved_b_d;
      saved_flags_q <= saved_flags_d;
      flags_q       <= flags_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_opc_q     <= alu_opc_d;
      error_q       <= error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hist_d        = hist_q;
    depth_d       = depth_q;
    saved_a_d     = saved_a_q;
    saved_b_d     = saved_b_q;
    saved_flags_d = saved_flags_q;
    flags_d       = flags_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_opc_d     = alu_opc_q;
    error_d       = error_q;
    wa_en         = 1'b0;
    wa_addr       = '0;
    wa_data       = '0;
    wb_en         = 1'b0;
    wb_addr       = '0;
    wb_data       = '0;

    unique case (state_q)
      StIdle: begin
        // Priority undo > op > enter; losers are simply dropped.
        if (undo_pulse) begin
          if (hist_q == HistPush) begin
            depth_d = depth_q - DW'(1);
            hist_d  = HistNone;
            error_d = 1'b0;
          end else if (hist_q == HistOp) begin
            // Result slot gets operand a back; b lands one above it.
            wa_en   = 1'b1;
            wa_addr = AW'(depth_q - DW'(1));
            wa_data = saved_a_q;
            wb_en   = 1'b1;
            wb_addr = AW'(depth_q);
            wb_data = saved_b_q;
            depth_d = depth_q + DW'(1);
            flags_d = saved_flags_q;
            hist_d  = HistNone;
            error_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end else if (op_pulse) begin
          if (depth_q >= DW'(2)) begin
            alu_a_d       = rd_next;
            alu_b_d       = rd_top;
            alu_opc_d     = opcode_in;
            saved_a_d     = rd_next;
            saved_b_d     = rd_top;
            saved_flags_d = flags_q;
            state_d       = StExec;
          end else begin
            error_d = 1'b1;
          end
        end else if (enter_pulse) begin
          if (depth_q < DepthMax) begin
            wa_en   = 1'b1;
            wa_addr = AW'(depth_q);
            wa_data = data_in;
            depth_d = depth_q + DW'(1);
            hist_d  = HistPush;
            error_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StExec: begin
        wa_en   = 1'b1;
        wa_addr = AW'(depth_q - DW'(2));
        wa_data = alu_result;
        flags_d = alu_flags;
        depth_d = depth_q - DW'(1);
        hist_d  = HistOp;
        error_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    alu_a      = alu_a_q;
    alu_b      = alu_b_q;
    alu_opcode = alu_opc_q;
    top        = rd_top;
    depth      = depth_q;
    flags      = flags_q;
    busy       = (state_q == StExec);
    error      = error_q;
    status     = {error_q, (state_q == StExec), (hist_q != HistNone)};
  end

endmodule

// File: doc/rpn_stack_controller.md
# rpn_stack_controller

Sequencing controller that turns the single combinational ALU of the RPN calculator into a stack machine. It holds a small operand stack, pushes user data on Enter, and on an operation pulse pops two operands into the ALU and writes the result back with its flags. It provides a one-level Undo of the last accepted push or operation. It sits between the level-to-pulse front end and the ALU/display path, replacing fixed OpA/OpB registers.

## Interface
Parameters:
- WIDTH, 16, operand/result width
- DEPTH, 4, stack entries (≥2)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- enter_pulse  in  1  one-cycle push request
- op_pulse  in  1  one-cycle operate request
- undo_pulse  in  1  one-cycle undo request
- data_in  in  WIDTH  value pushed on enter
- opcode_in  in  2  ALU opcode sampled on op
- alu_result  in  WIDTH  combinational ALU result
- alu_flags  in  5  ALU flags {N,Z,C,V,P}
- alu_a, alu_b  out  WIDTH  registered ALU operands (a = deeper entry)
- alu_opcode  out  2  registered opcode
- top  out  WIDTH  top of stack; 0 when empty
- depth  out  $clog2(DEPTH+1)  entries in use
- flags  out  5  flags of last completed operation
- busy  out  1  high during EXEC
- error  out  1  sticky; set by rejected request
- status  out  3  {error, busy, undo_available}

## Operation
- States: IDLE, EXEC.
- IDLE, one request accepted per cycle; priority undo > op > enter; lower-priority simultaneous pulses are dropped.
- Enter: depth<DEPTH → stack[depth]=data_in, depth+1, history={PUSH}, error cleared. Full → no change, error=1.
- Op: depth≥2 → alu_a=stack[depth-2], alu_b=stack[depth-1], alu_opcode=opcode_in, save both operands and current flags to history, → EXEC. depth<2 → no change, error=1.
- EXEC (one cycle): stack[depth-2]=alu_result, flags=alu_flags, depth−1, history={OP}, error cleared, → IDLE. All pulses in EXEC are ignored (not queued, no error).
- Undo: history PUSH → depth−1. History OP → stack[depth-1]=saved_a, stack[depth]=saved_b, depth+1, flags=saved flags. Either way history cleared, error cleared. No history → no change, error=1.
- Only one undo level; a second undo without an intervening accepted enter/op sets error.
- Arithmetic is entirely in the ALU; controller never modifies data; widths match exactly, no extension.

## Timing
- Reset: state IDLE, depth 0, all stack entries 0, alu_a/alu_b/alu_opcode 0, flags 0, top 0, busy 0, error 0, history empty, status 3'b000.
- Enter/undo: effect visible on top/depth the cycle after the pulse edge.
- Op: pulse at edge t → operands registered at t, busy=1 during cycle t..t+1; writeback at edge t+1; top shows result from t+1. Latency 2 edges, throughput one op per 2 cycles.
- alu_a/alu_b/alu_opcode hold their last values after EXEC (display/debug stable).
- Reset asserted during EXEC: writeback discarded, full reset values next cycle.
- Undo of an op whose writeback left depth=DEPTH−1 restores to DEPTH; never overflows since op reduced depth by one.

## Structure
- Package rpn_ctrl_pkg: state enum (IDLE, EXEC), history kind enum (NONE, PUSH, OP), opcode constants, flag bit indices N=4..P=0.
- Sub-module operand_stack_regfile (DEPTH×WIDTH, two read ports at depth-1/depth-2, two write ports for undo restore, sync reset to 0).
- Controller FSM, depth counter, history registers and error logic in the top.

## Test plan
- Reset, enter 5, enter 3, op ADD (00) → alu_a=5, alu_b=3, busy one cycle, top=8, depth=1, flags Z=0.
- Push 0x7FFF, 0x0001, op ADD → top=0x8000, flags N=1,V=1; undo → depth=2, top=0x0001, stack[0]=0x7FFF, flags restored 0.
- DEPTH=4: push 1,2,3,4, push 5 → error=1, depth=4, top=4; next enter after undo clears error.
- Depth=1, op → error=1, busy stays 0; undo twice after one enter → depth 0, then error=1.
- Enter+op+undo pulses same cycle with history PUSH → only undo applied; op pulse during EXEC → ignored, single writeback.
- Reset asserted in EXEC cycle → depth 0, top 0, flags 0, status 000 next cycle.
